// File: rtl/wfg_stim_ramp_pkg.sv
// wfg_stim_ramp_pkg: shared types for the ramp stimulus generator.
// The triangle feature is compiled in with `WFG_STIM_RAMP_TRIANGLE_EN`.
package wfg_stim_ramp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        MODE_SAWTOOTH = 1'b0,
        MODE_TRIANGLE = 1'b1
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/wfg_stim_ramp_step.sv
// wfg_stim_ramp_step: combinational successor logic for the ramp.
// Given the current sample, direction and configuration it returns the
// next sample, its direction and whether that sample ends a period.
// With `restart` set the result is the first sample of a new run.
// The triangle path (subtractor, clamps, direction) exists only when
// `WFG_STIM_RAMP_TRIANGLE_EN` is defined.
module wfg_stim_ramp_step
    import wfg_stim_ramp_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                       restart,
    input  logic [AXIS_DATA_WIDTH-1:0] cur,
    input  dir_t                       dir,
    input  mode_t                      mode,
    input  logic [AXIS_DATA_WIDTH-1:0] start,
    input  logic [AXIS_DATA_WIDTH-1:0] stop,
    input  logic [AXIS_DATA_WIDTH-1:0] inc,
    output logic [AXIS_DATA_WIDTH-1:0] next_val,
    output dir_t                       next_dir,
    output logic                       next_tlast
);

    localparam int W = AXIS_DATA_WIDTH;

    // Sawtooth sample x wraps when x+inc carries, passes stop, or inc is zero
    function automatic logic saw_wraps_f(
        input logic [W-1:0] x,
        input logic [W-1:0] step_v,
        input logic [W-1:0] bound_v
    );
        logic [W:0] sum_v;
        sum_v = {1'b0, x} + {1'b0, step_v};
        return (sum_v > {1'b0, bound_v}) || (step_v == {W{1'b0}});
    endfunction

    logic [W-1:0] saw_val_s;
    logic         saw_tlast_s;

    // Sawtooth successor; tlast looks one step ahead from the new sample
    always_comb begin
        saw_val_s = start;
        if (restart) begin
            saw_val_s = start;
        end else if (saw_wraps_f(cur, inc, stop)) begin
            saw_val_s = start;
        end else begin
            saw_val_s = cur + inc;
        end
        saw_tlast_s = saw_wraps_f(saw_val_s, inc, stop);
    end

`ifdef WFG_STIM_RAMP_TRIANGLE_EN
    logic [W:0]   up_sum_s;
    logic [W:0]   dn_diff_s;
    logic         degenerate_s;
    logic [W-1:0] tri_val_s;
    dir_t         tri_dir_s;
    logic         tri_tlast_s;

    // Triangle successor: clamp at stop going up, at start going down
    always_comb begin
        up_sum_s     = {1'b0, cur} + {1'b0, inc};
        dn_diff_s    = {1'b0, cur} - {1'b0, inc};
        degenerate_s = (start >= stop) || (inc == {W{1'b0}});
        tri_val_s    = start;
        tri_dir_s    = DIR_UP;
        tri_tlast_s  = 1'b0;
        if (restart || degenerate_s) begin
            tri_val_s   = start;
            tri_dir_s   = DIR_UP;
            tri_tlast_s = degenerate_s;
        end else if (dir == DIR_UP) begin
            if (up_sum_s > {1'b0, stop}) begin
                tri_val_s = stop;
            end else begin
                tri_val_s = up_sum_s[W-1:0];
            end
            tri_dir_s   = (tri_val_s == stop) ? DIR_DOWN : DIR_UP;
            tri_tlast_s = 1'b0;
        end else begin
            if (dn_diff_s[W] || (dn_diff_s[W-1:0] < start)) begin
                tri_val_s = start;
            end else begin
                tri_val_s = dn_diff_s[W-1:0];
            end
            tri_dir_s   = (tri_val_s == start) ? DIR_UP : DIR_DOWN;
            tri_tlast_s = (tri_val_s == start);
        end
    end

    // Select the waveform requested by the latched mode
    always_comb begin
        next_val   = saw_val_s;
        next_dir   = DIR_UP;
        next_tlast = saw_tlast_s;
        if (mode == MODE_TRIANGLE) begin
            next_val   = tri_val_s;
            next_dir   = tri_dir_s;
            next_tlast = tri_tlast_s;
        end else begin
            next_val   = saw_val_s;
            next_dir   = DIR_UP;
            next_tlast = saw_tlast_s;
        end
    end
`else
    logic unused_s;

    assign unused_s = (dir == DIR_DOWN) ^ (mode == MODE_TRIANGLE);

    // Sawtooth only: direction never leaves up
    always_comb begin
        next_val   = saw_val_s;
        next_dir   = DIR_UP;
        next_tlast = saw_tlast_s;
    end
`endif

endmodule

// File: rtl/wfg_stim_ramp.sv
// wfg_stim_ramp: sawtooth (optionally triangle) ramp as an AXI-Stream master.
// Configuration is shadowed at enable so live register writes do not
// disturb a running ramp. Outputs come straight from registers.
// Triangle mode is built only when `WFG_STIM_RAMP_TRIANGLE_EN` is defined.
module wfg_stim_ramp
    import wfg_stim_ramp_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       ctrl_en_q_i,
    input  logic                       cfg_mode_q_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_start_q_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_stop_q_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_inc_q_i,
    input  logic                       wfg_stim_ramp_tready_i,
    output logic                       wfg_stim_ramp_tvalid_o,
    output logic [AXIS_DATA_WIDTH-1:0] wfg_stim_ramp_tdata_o,
    output logic                       wfg_stim_ramp_tlast_o
);

    localparam int W = AXIS_DATA_WIDTH;

    state_t       state_r;
    state_t       state_s;
    logic         tvalid_r;
    logic         tvalid_s;
    logic [W-1:0] tdata_r;
    logic [W-1:0] tdata_s;
    logic         tlast_r;
    logic         tlast_s;
    logic [W-1:0] start_r;
    logic [W-1:0] stop_r;
    logic [W-1:0] inc_r;

    logic         hs_s;
    logic         load_cfg_s;
    logic         advance_s;
    logic         restart_s;
    logic [W-1:0] step_start_s;
    logic [W-1:0] step_stop_s;
    logic [W-1:0] step_inc_s;
    mode_t        step_mode_s;
    dir_t         step_dir_s;
    logic [W-1:0] step_val_s;
    dir_t         step_next_dir_s;
    logic         step_tlast_s;

`ifdef WFG_STIM_RAMP_TRIANGLE_EN
    mode_t        mode_r;
    dir_t         dir_r;
`else
    logic         unused_cfg_s;

    assign unused_cfg_s = cfg_mode_q_i ^ (step_next_dir_s == DIR_DOWN);
`endif

    // Starting a run uses the live config; a running ramp uses the shadows
    always_comb begin
        restart_s    = (state_r == ST_IDLE);
        step_start_s = start_r;
        step_stop_s  = stop_r;
        step_inc_s   = inc_r;
        if (restart_s) begin
            step_start_s = cfg_start_q_i;
            step_stop_s  = cfg_stop_q_i;
            step_inc_s   = cfg_inc_q_i;
        end else begin
            step_start_s = start_r;
            step_stop_s  = stop_r;
            step_inc_s   = inc_r;
        end
`ifdef WFG_STIM_RAMP_TRIANGLE_EN
        step_mode_s = restart_s ? mode_t'(cfg_mode_q_i) : mode_r;
        step_dir_s  = dir_r;
`else
        step_mode_s = MODE_SAWTOOTH;
        step_dir_s  = DIR_UP;
`endif
    end

    wfg_stim_ramp_step #(
        .AXIS_DATA_WIDTH (W)
    ) u_step (
        .restart    (restart_s),
        .cur        (tdata_r),
        .dir        (step_dir_s),
        .mode       (step_mode_s),
        .start      (step_start_s),
        .stop       (step_stop_s),
        .inc        (step_inc_s),
        .next_val   (step_val_s),
        .next_dir   (step_next_dir_s),
        .next_tlast (step_tlast_s)
    );

    // Next-state and output-register logic for IDLE / RUN / DRAIN
    always_comb begin
        state_s    = state_r;
        tvalid_s   = tvalid_r;
        tdata_s    = tdata_r;
        tlast_s    = tlast_r;
        load_cfg_s = 1'b0;
        advance_s  = 1'b0;
        hs_s       = tvalid_r && wfg_stim_ramp_tready_i;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_en_q_i) begin
                    load_cfg_s = 1'b1;
                    advance_s  = 1'b1;
                    tvalid_s   = 1'b1;
                    tdata_s    = step_val_s;
                    tlast_s    = step_tlast_s;
                    state_s    = ST_RUN;
                end else begin
                    tvalid_s = 1'b0;
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hs_s && ctrl_en_q_i) begin
                    advance_s = 1'b1;
                    tdata_s   = step_val_s;
                    tlast_s   = step_tlast_s;
                    state_s   = ST_RUN;
                end else if (hs_s) begin
                    tvalid_s = 1'b0;
                    state_s  = ST_IDLE;
                end else if (!ctrl_en_q_i) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (hs_s) begin
                    tvalid_s = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                tvalid_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and AXI-Stream output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r  <= ST_IDLE;
            tvalid_r <= 1'b0;
            tdata_r  <= {W{1'b0}};
            tlast_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            tvalid_r <= tvalid_s;
            tdata_r  <= tdata_s;
            tlast_r  <= tlast_s;
        end
    end

    // Shadow configuration captured when a run starts
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_r <= {W{1'b0}};
            stop_r  <= {W{1'b0}};
            inc_r   <= {W{1'b0}};
        end else if (load_cfg_s) begin
            start_r <= cfg_start_q_i;
            stop_r  <= cfg_stop_q_i;
            inc_r   <= cfg_inc_q_i;
        end else begin
            start_r <= start_r;
            stop_r  <= stop_r;
            inc_r   <= inc_r;
        end
    end

`ifdef WFG_STIM_RAMP_TRIANGLE_EN
    // Triangle mode and direction, updated with each loaded sample
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mode_r <= MODE_SAWTOOTH;
            dir_r  <= DIR_UP;
        end else begin
            if (load_cfg_s) begin
                mode_r <= mode_t'(cfg_mode_q_i);
            end else begin
                mode_r <= mode_r;
            end
            if (advance_s) begin
                dir_r <= step_next_dir_s;
            end else begin
                dir_r <= dir_r;
            end
        end
    end
`endif

    assign wfg_stim_ramp_tvalid_o = tvalid_r;
    assign wfg_stim_ramp_tdata_o  = tdata_r;
    assign wfg_stim_ramp_tlast_o  = tlast_r;

endmodule
